// File: rtl/fetch_decode_stage_if.sv
// Instruction-memory fetch port between the front-end and program memory.
// The fetch side drives the address; read data returns in the same cycle.
interface fetch_decode_stage_if #(
    parameter int unsigned XLEN = 64
);
    logic [XLEN-1:0] imem_addr;
    logic [31:0]     imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_decode_stage.sv
// Fetch/decode front-end: PC sequencing with redirect, IF/ID register
// with stall/flush, and a register file with same-cycle write bypass.
module fetch_decode_stage #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     REG_AW   = 5,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_decode_stage_if.master imem,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [XLEN-1:0]      redirect_pc,
    input  logic                 wb_en,
    input  logic [REG_AW-1:0]    wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    output logic                 id_valid,
    output logic [XLEN-1:0]      id_pc,
    output logic [31:0]          id_instr,
    output logic [REG_AW-1:0]    id_rd,
    output logic [XLEN-1:0]      id_rs1_data,
    output logic [XLEN-1:0]      id_rs2_data
);
    localparam int unsigned     NREG       = 1 << REG_AW;
    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } if_id_t;

    logic [XLEN-1:0]   pc_q, pc_d;
    if_id_t            id_q, id_d;
    logic [XLEN-1:0]   rf_q [NREG];
    logic [XLEN-1:0]   rf_d [NREG];
    logic              wr_en;
    logic              byp_en;
    logic [REG_AW-1:0] rs1, rs2;

    assign wr_en  = wb_en && (wb_addr != '0);
    // Reset suppresses the write, so it must suppress the bypass as well.
    assign byp_en = wr_en && rst_n;

    always_comb begin
        pc_d = pc_q;
        id_d = id_q;
        if (redirect) begin
            pc_d     = redirect_pc & ALIGN_MASK;
            id_d.valid = 1'b0;
            id_d.instr = NOP;
        end else if (!stall) begin
            pc_d       = pc_q + PC_STEP;
            id_d.valid = 1'b1;
            id_d.pc    = pc_q;
            id_d.instr = imem.imem_rdata;
        end
    end

    always_comb begin
        rf_d = rf_q;
        if (wr_en) begin
            rf_d[wb_addr] = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
            id_q <= '{valid: 1'b0, pc: '0, instr: NOP};
            rf_q <= '{default: '0};
        end else begin
            pc_q <= pc_d;
            id_q <= id_d;
            rf_q <= rf_d;
        end
    end

    assign imem.imem_addr = pc_q;
    assign id_valid       = id_q.valid;
    assign id_pc          = id_q.pc;
    assign id_instr       = id_q.instr;
    assign id_rd          = id_q.instr[7 +: REG_AW];
    assign rs1            = id_q.instr[15 +: REG_AW];
    assign rs2            = id_q.instr[20 +: REG_AW];

    always_comb begin
        id_rs1_data = rf_q[rs1];
        if (rs1 == '0) begin
            id_rs1_data = '0;
        end else if (byp_en && (wb_addr == rs1)) begin
            id_rs1_data = wb_data;
        end
    end

    always_comb begin
        id_rs2_data = rf_q[rs2];
        if (rs2 == '0) begin
            id_rs2_data = '0;
        end else if (byp_en && (wb_addr == rs2)) begin
            id_rs2_data = wb_data;
        end
    end
endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios plus random traffic
// checked against an architectural model of the front-end.
module tb_fetch_decode_stage;
    localparam logic [63:0] RPC = 64'h1000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [1:0]  mem_mode = 2'd0;
    logic [31:0] fixed_word = NOP;

    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [63:0] wb_data = '0;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;
    logic [4:0]  id_rd;
    logic [63:0] id_rs1_data;
    logic [63:0] id_rs2_data;
    logic [31:0] rdata64;

    fetch_decode_stage_if #(.XLEN(64)) bus64 ();

    always_comb begin
        case (mem_mode)
            2'd0:    rdata64 = 32'hA000_0000 + bus64.imem_addr[31:0];
            2'd1:    rdata64 = fixed_word;
            default: rdata64 = (bus64.imem_addr[31:0] * 32'h9E37_79B1)
                               ^ 32'h5A5A_0013;
        endcase
    end
    assign bus64.imem_rdata = rdata64;

    fetch_decode_stage #(.XLEN(64), .REG_AW(5), .RESET_PC(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .imem(bus64),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data)
    );

    logic        rst32_n = 1'b0;
    logic        redirect32 = 1'b0;
    logic [31:0] rp32 = '0;
    logic        zero1 = 1'b0;
    logic [4:0]  zero5 = '0;
    logic [31:0] zero32 = '0;
    logic        id_valid32;
    logic [31:0] id_pc32;
    logic [31:0] id_instr32;
    logic [4:0]  id_rd32;
    logic [31:0] rs1_32;
    logic [31:0] rs2_32;

    fetch_decode_stage_if #(.XLEN(32)) bus32 ();
    assign bus32.imem_rdata = 32'hA000_0000 + bus32.imem_addr;

    fetch_decode_stage #(.XLEN(32), .REG_AW(5), .RESET_PC(32'h0)) dut32 (
        .clk(clk), .rst_n(rst32_n), .imem(bus32),
        .stall(zero1), .redirect(redirect32), .redirect_pc(rp32),
        .wb_en(zero1), .wb_addr(zero5), .wb_data(zero32),
        .id_valid(id_valid32), .id_pc(id_pc32), .id_instr(id_instr32),
        .id_rd(id_rd32), .id_rs1_data(rs1_32), .id_rs2_data(rs2_32)
    );

    // Architectural model of the 64-bit instance
    logic [63:0] m_pc;
    logic        m_v;
    logic [63:0] m_idpc;
    logic [31:0] m_instr;
    logic [63:0] m_rf [32];

    function automatic logic [31:0] memfn(input logic [63:0] a);
        case (mem_mode)
            2'd0:    return 32'hA000_0000 + a[31:0];
            2'd1:    return fixed_word;
            default: return (a[31:0] * 32'h9E37_79B1) ^ 32'h5A5A_0013;
        endcase
    endfunction

    function automatic logic [63:0] exp_rs(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
        if (rst_n && wb_en && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    task automatic step();
        logic [31:0] w;
        w = memfn(m_pc);
        if (!rst_n) begin
            m_pc    = RPC;
            m_v     = 1'b0;
            m_idpc  = '0;
            m_instr = NOP;
            for (int i = 0; i < 32; i++) m_rf[i] = '0;
        end else begin
            if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
            if (redirect) begin
                m_pc    = {redirect_pc[63:2], 2'b00};
                m_v     = 1'b0;
                m_instr = NOP;
            end else if (!stall) begin
                m_v     = 1'b1;
                m_idpc  = m_pc;
                m_instr = w;
                m_pc    = m_pc + 64'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus64.imem_addr !== 64'h1000) begin
            errors++;
            $display("FAIL reset_pc: got %h want %h", bus64.imem_addr, 64'h1000);
        end
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b want 0", id_valid);
        end
        checks++;
        if (id_instr !== NOP) begin
            errors++;
            $display("FAIL reset_instr: got %h want %h", id_instr, NOP);
        end
        checks++;
        if (id_pc !== 64'h0) begin
            errors++;
            $display("FAIL reset_idpc: got %h want 0", id_pc);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (id_pc !== 64'h1000 + 64'(4 * i) || id_valid !== 1'b1 ||
                id_instr !== 32'hA000_1000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL seq%0d: got pc=%h v=%b instr=%h want pc=%h v=1 instr=%h",
                         i, id_pc, id_valid, id_instr,
                         64'h1000 + 64'(4 * i), 32'hA000_1000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus64.imem_addr !== 64'h1008 || id_pc !== 64'h1004 ||
                id_instr !== 32'hA000_1004 || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL stall%0d: got addr=%h pc=%h instr=%h v=%b want addr=1008 pc=1004 instr=a0001004 v=1",
                         i, bus64.imem_addr, id_pc, id_instr, id_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (id_pc !== 64'h1008 || id_instr !== 32'hA000_1008 ||
            bus64.imem_addr !== 64'h100C) begin
            errors++;
            $display("FAIL stall_resume: got pc=%h instr=%h addr=%h want 1008/a0001008/100c",
                     id_pc, id_instr, bus64.imem_addr);
        end
    endtask

    task automatic test_redirect();
        redirect    = 1'b1;
        stall       = 1'b1;
        redirect_pc = 64'h2002;
        step();
        redirect = 1'b0;
        stall    = 1'b0;
        checks++;
        if (bus64.imem_addr !== 64'h2000 || id_valid !== 1'b0 ||
            id_instr !== NOP || id_pc !== 64'h1008) begin
            errors++;
            $display("FAIL redirect_squash: got addr=%h v=%b instr=%h pc=%h want 2000/0/00000013/1008",
                     bus64.imem_addr, id_valid, id_instr, id_pc);
        end
        step();
        checks++;
        if (id_pc !== 64'h2000 || id_valid !== 1'b1 ||
            id_instr !== 32'hA000_2000) begin
            errors++;
            $display("FAIL redirect_target: got pc=%h v=%b instr=%h want 2000/1/a0002000",
                     id_pc, id_valid, id_instr);
        end
    endtask

    task automatic test_regfile();
        mem_mode   = 2'd1;
        fixed_word = 32'h0002_8393;
        step();
        checks++;
        if (id_rd !== 5'd7) begin
            errors++;
            $display("FAIL rd_field: got %0d want 7", id_rd);
        end
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 64'hDEAD_BEEF_0000_0001;
        #1;
        checks++;
        if (id_rs1_data !== 64'hDEAD_BEEF_0000_0001 || id_rs2_data !== 64'd0) begin
            errors++;
            $display("FAIL bypass: got rs1=%h rs2=%h want deadbeef00000001/0",
                     id_rs1_data, id_rs2_data);
        end
        step();
        wb_en = 1'b0;
        #1;
        checks++;
        if (id_rs1_data !== 64'hDEAD_BEEF_0000_0001) begin
            errors++;
            $display("FAIL array_read: got %h want deadbeef00000001", id_rs1_data);
        end
        wb_en   = 1'b1;
        wb_addr = 5'd0;
        wb_data = '1;
        #1;
        checks++;
        if (id_rs2_data !== 64'd0) begin
            errors++;
            $display("FAIL x0_bypass: got %h want 0", id_rs2_data);
        end
        step();
        wb_en = 1'b0;
        #1;
        checks++;
        if (id_rs2_data !== 64'd0) begin
            errors++;
            $display("FAIL x0_write: got %h want 0", id_rs2_data);
        end
        stall   = 1'b1;
        wb_en   = 1'b1;
        wb_addr = 5'd5;
        wb_data = 64'h1234_5678_9ABC_DEF0;
        step();
        wb_en = 1'b0;
        stall = 1'b0;
        step();
        checks++;
        if (id_rs1_data !== 64'h1234_5678_9ABC_DEF0) begin
            errors++;
            $display("FAIL stall_write: got %h want 123456789abcdef0", id_rs1_data);
        end
    endtask

    task automatic test_random();
        logic [63:0] e1, e2;
        mem_mode = 2'd2;
        for (int n = 0; n < 250; n++) begin
            rst_n       = ($urandom_range(0, 49) != 0);
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 9) == 0);
            redirect_pc = {$urandom, $urandom};
            wb_en       = ($urandom_range(0, 1) == 1);
            wb_addr     = ($urandom_range(0, 2) == 0) ? m_instr[19:15]
                                                      : 5'($urandom);
            wb_data     = {$urandom, $urandom};
            #1;
            e1 = exp_rs(m_instr[19:15]);
            e2 = exp_rs(m_instr[24:20]);
            checks++;
            if (bus64.imem_addr !== m_pc || id_valid !== m_v ||
                id_pc !== m_idpc || id_instr !== m_instr ||
                id_rd !== m_instr[11:7] ||
                id_rs1_data !== e1 || id_rs2_data !== e2) begin
                errors++;
                $display("FAIL random%0d: got addr=%h v=%b pc=%h ins=%h rd=%h rs1=%h rs2=%h want %h %b %h %h %h %h %h",
                         n, bus64.imem_addr, id_valid, id_pc, id_instr,
                         id_rd, id_rs1_data, id_rs2_data, m_pc, m_v,
                         m_idpc, m_instr, m_instr[11:7], e1, e2);
            end
            step();
        end
        rst_n    = 1'b1;
        stall    = 1'b0;
        redirect = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic test_reset_midstream();
        mem_mode = 2'd0;
        wb_en    = 1'b1;
        wb_addr  = 5'd5;
        wb_data  = 64'hAAAA_5555_AAAA_5555;
        step();
        rst_n   = 1'b0;
        stall   = 1'b1;
        wb_addr = 5'd6;
        step();
        rst_n = 1'b1;
        stall = 1'b0;
        wb_en = 1'b0;
        checks++;
        if (bus64.imem_addr !== 64'h1000 || id_valid !== 1'b0 ||
            id_instr !== NOP) begin
            errors++;
            $display("FAIL midreset: got addr=%h v=%b instr=%h want 1000/0/00000013",
                     bus64.imem_addr, id_valid, id_instr);
        end
        mem_mode = 2'd1;
        for (int i = 0; i < 32; i++) begin
            fixed_word = {7'd0, 5'(31 - i), 5'(i), 3'd0, 5'd0, 7'h13};
            step();
            checks++;
            if (id_rs1_data !== 64'd0 || id_rs2_data !== 64'd0) begin
                errors++;
                $display("FAIL reg_cleared x%0d: got rs1=%h rs2=%h want 0/0",
                         i, id_rs1_data, id_rs2_data);
            end
        end
    endtask

    task automatic test_wrap();
        rst32_n    = 1'b1;
        redirect32 = 1'b1;
        rp32       = 32'hFFFF_FFFC;
        step();
        redirect32 = 1'b0;
        checks++;
        if (bus32.imem_addr !== 32'hFFFF_FFFC || id_valid32 !== 1'b0) begin
            errors++;
            $display("FAIL wrap_redirect: got addr=%h v=%b want fffffffc/0",
                     bus32.imem_addr, id_valid32);
        end
        step();
        checks++;
        if (id_pc32 !== 32'hFFFF_FFFC || id_instr32 !== 32'h9FFF_FFFC ||
            id_valid32 !== 1'b1 || bus32.imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_edge: got pc=%h instr=%h v=%b addr=%h want fffffffc/9ffffffc/1/0",
                     id_pc32, id_instr32, id_valid32, bus32.imem_addr);
        end
        step();
        checks++;
        if (id_pc32 !== 32'h0 || id_instr32 !== 32'hA000_0000) begin
            errors++;
            $display("FAIL wrap_after: got pc=%h instr=%h want 0/a0000000",
                     id_pc32, id_instr32);
        end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect();
        test_regfile();
        test_random();
        test_reset_midstream();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
